// File: rtl/multi_dataflow_mac_mdc_stream_sink_pkg.sv
// Shared types and default widths for the MAC engine stream sink.
// Optional strobe pass-through is selected with MULTI_DATAFLOW_MAC_MDC_SINK_STRB_EN.
package multi_dataflow_mac_mdc_package;

  localparam int unsigned MULTI_DATAFLOW_MAC_MDC_SINK_CNT_WIDTH  = 16;
  localparam int unsigned MULTI_DATAFLOW_MAC_MDC_SINK_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    SINK_IDLE = 2'd0,
    SINK_RUN  = 2'd1,
    SINK_DONE = 2'd2
  } sink_state_multi_dataflow_mac_mdc_t;

endpackage

// File: rtl/multi_dataflow_mac_mdc_stream_sink_buffer.sv
// One-entry data+strobe holding register: stream valid/ready in, memory req/gnt out.
// Decouples stream backpressure from memory grant without a bubble on reload.
module multi_dataflow_mac_mdc_sink_buffer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o
);

  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    accept;

  // A grant frees the slot in the same cycle, so a new beat can land immediately.
  assign ready_o = (~valid_q | gnt_i) & en_i;
  assign accept  = valid_i & ready_o;
  assign req_o   = valid_q;
  assign data_o  = data_q;
  assign strb_o  = strb_q;

  // NOTE: non-blocking assignments for every register so all flops update from
  // pre-edge values; the data register is reset too because its idle value is visible on the bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      strb_q  <= strb_i;
    end else if (gnt_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_dataflow_mac_mdc_stream_sink.sv
// MAC engine output stream sink: writes beats to TCDM at strided addresses.
// Define MULTI_DATAFLOW_MAC_MDC_SINK_STRB_EN to forward stream strobes as byte enables.
module multi_dataflow_mac_mdc_stream_sink
  import multi_dataflow_mac_mdc_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = MULTI_DATAFLOW_MAC_MDC_SINK_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = MULTI_DATAFLOW_MAC_MDC_SINK_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic [DATA_WIDTH-1:0]   stream_data_i,
  input  logic [DATA_WIDTH/8-1:0] stream_strb_i,
  input  logic                    stream_valid_i,
  output logic                    stream_ready_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_add_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    cnt_o
);

  sink_state_multi_dataflow_mac_mdc_t state_q;

  logic [ADDR_WIDTH-1:0]   addr_q, stride_q;
  logic [CNT_WIDTH-1:0]    len_q, cnt_q, acc_q, cnt_next;
  logic [DATA_WIDTH/8-1:0] strb_in;
  logic                    buf_en, beat_accept, mem_grant;

`ifdef MULTI_DATAFLOW_MAC_MDC_SINK_STRB_EN
  assign strb_in = stream_strb_i;
`else
  // Engine always drives full strobes; force all ones so byte enables never depend on it.
  assign strb_in = stream_strb_i | {(DATA_WIDTH/8){1'b1}};
`endif

  assign buf_en      = (state_q == SINK_RUN) && (acc_q < len_q);
  assign beat_accept = stream_valid_i & stream_ready_o;
  assign mem_grant   = mem_req_o & mem_gnt_i;
  assign cnt_next    = cnt_q + CNT_WIDTH'(1);

  multi_dataflow_mac_mdc_sink_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) i_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .en_i    (buf_en),
    .data_i  (stream_data_i),
    .strb_i  (strb_in),
    .valid_i (stream_valid_i),
    .ready_o (stream_ready_o),
    .req_o   (mem_req_o),
    .gnt_i   (mem_gnt_i),
    .data_o  (mem_data_o),
    .strb_o  (mem_be_o)
  );

  assign mem_add_o = addr_q;
  assign mem_wen_o = 1'b0;
  assign busy_o    = (state_q == SINK_RUN);
  assign done_o    = (state_q == SINK_DONE);
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SINK_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else if (clear_i) begin
      state_q <= SINK_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        SINK_IDLE: begin
          if (start_i) begin
            addr_q   <= base_addr_i;
            stride_q <= stride_i;
            len_q    <= len_i;
            cnt_q    <= '0;
            acc_q    <= '0;
            state_q  <= (len_i != '0) ? SINK_RUN : SINK_DONE;
          end
        end
        SINK_RUN: begin
          if (beat_accept) acc_q <= acc_q + CNT_WIDTH'(1);
          if (mem_grant) begin
            cnt_q  <= cnt_next;
            addr_q <= addr_q + stride_q;
            if (cnt_next == len_q) state_q <= SINK_DONE;
          end
        end
        SINK_DONE: state_q <= SINK_IDLE;
        default:   state_q <= SINK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dataflow_mac_mdc_stream_sink.sv
// Randomized bench for the MAC stream sink against an address/data sequence model.
// Honours MULTI_DATAFLOW_MAC_MDC_SINK_STRB_EN for the expected byte enables.
module tb_multi_dataflow_mac_mdc_stream_sink;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, clear, start;
  logic [AW-1:0] base, stride;
  logic [CW-1:0] len;
  logic [DW-1:0] sdata;
  logic [3:0]    sstrb;
  logic          svalid, sready;
  logic          req, gnt, wen, busy, done;
  logic [AW-1:0] add;
  logic [3:0]    be;
  logic [DW-1:0] mdata;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  multi_dataflow_mac_mdc_stream_sink dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .start_i        (start),
    .base_addr_i    (base),
    .stride_i       (stride),
    .len_i          (len),
    .stream_data_i  (sdata),
    .stream_strb_i  (sstrb),
    .stream_valid_i (svalid),
    .stream_ready_o (sready),
    .mem_req_o      (req),
    .mem_gnt_i      (gnt),
    .mem_add_o      (add),
    .mem_wen_o      (wen),
    .mem_be_o       (be),
    .mem_data_o     (mdata),
    .busy_o         (busy),
    .done_o         (done),
    .cnt_o          (cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [3:0] s);
`ifdef MULTI_DATAFLOW_MAC_MDC_SINK_STRB_EN
    return s;
`else
    return 4'hF;
`endif
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  // gmode: 0 grant tied high, 1 toggling 1,0,1..., 2 random. extra: beats offered beyond len.
  task automatic run_xfer(input int len_v, input logic [AW-1:0] base_v, input logic [AW-1:0] stride_v,
                          input int gmode, input int extra, input bit vcont, input logic [3:0] strb_v);
    logic [DW-1:0] beats[$];
    logic [AW-1:0] pend_add, ea;
    logic [DW-1:0] pend_data;
    int  n = len_v + extra;
    int  src = 0, accepted = 0, k = 0, dones = 0, done_cyc = -1, last_grant = -1, c0, i = 0;
    bit  pend = 0, acc_prev = 0, gtog = 1'b1, first = 1'b1;

    for (int j = 0; j < n; j++) beats.push_back($urandom());
    next_cycle();
    start = 1'b1; len = CW'(len_v); base = base_v; stride = stride_v;
    svalid = 1'b0; gnt = 1'b0; sstrb = strb_v;
    c0 = cyc;
    next_cycle();
    start = 1'b0;

    while (i < 300 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
      if (!(svalid && !acc_prev)) begin
        svalid = (src < n) && (vcont || $urandom_range(0, 3) != 0);
        sdata  = (src < n) ? beats[src] : '0;
      end
      case (gmode)
        0:       gnt = 1'b1;
        1:       begin gnt = gtog; gtog = ~gtog; end
        default: gnt = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (first && len_v > 0) begin
        check("busy_after_start", busy, 1);
        check("ready_after_start", sready, 1);
      end
      first = 1'b0;
      if (pend) begin
        check("req_held", req, 1);
        check("addr_held", add, pend_add);
        check("data_held", mdata, pend_data);
      end
      if (req && gnt) begin
        if (k >= len_v) check("extra_grant", 1, 0);
        else begin
          ea = base_v + stride_v * AW'(k);
          check("wr_addr", add, ea);
          check("wr_data", mdata, beats[k]);
          check("wr_be", be, exp_be(strb_v));
          check("wr_wen", wen, 0);
        end
        k++;
        last_grant = cyc;
      end
      pend      = req && !gnt;
      pend_add  = add;
      pend_data = mdata;
      acc_prev  = svalid && sready;
      if (acc_prev) begin accepted++; src++; end
      if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      next_cycle();
      i++;
    end
    svalid = 1'b0;
    gnt    = 1'b0;

    if (done_cyc < 0) check("done_timeout", 0, 1);
    check("accepted", accepted, len_v);
    check("grants", k, len_v);
    check("done_pulses", dones, 1);
    check("cnt_final", cnt, len_v);
    check("busy_idle", busy, 0);
    check("ready_idle", sready, 0);
    if (len_v > 0) check("done_after_last_grant", done_cyc, last_grant + 1);
    else           check("zero_len_done_latency", (done_cyc > c0) && (done_cyc <= c0 + 2), 1);
    if (gmode == 0 && vcont && len_v > 0) check("stream_latency", done_cyc, c0 + len_v + 2);
  endtask

  task automatic run_clear();
    int k = 0, reqs = 0, dones = 0;
    bit hit = 0;
    next_cycle();
    start = 1'b1; len = CW'(4); base = $urandom(); stride = 32'd4; gnt = 1'b0; svalid = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      svalid = 1'b1;
      sdata  = $urandom();
      gnt    = (k == 0);
      #1;
      if (req && gnt) k++;
      else if (req && k == 1) hit = 1'b1;
      next_cycle();
    end
    if (!hit) check("clear_setup_timeout", 0, 1);
    clear = 1'b1; gnt = 1'b0; svalid = 1'b0;
    #1;
    check("req_before_clear", req, 1);
    check("cnt_before_clear", cnt, 1);
    next_cycle();
    clear = 1'b0;
    #1;
    check("clear_req", req, 0);
    check("clear_cnt", cnt, 0);
    check("clear_busy", busy, 0);
    check("clear_addr", add, 0);
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      if (req) reqs++;
      next_cycle();
    end
    check("clear_no_done", dones, 0);
    check("clear_no_req", reqs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; base = '0; stride = '0; len = '0;
    sdata = '0; sstrb = 4'hF; svalid = 1'b0; gnt = 1'b0;
    next_cycle();
    next_cycle();
    check("rst_req", req, 0);
    check("rst_addr", add, 0);
    check("rst_data", mdata, 0);
    check("rst_be", be, 0);
    check("rst_wen", wen, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ready", sready, 0);
    rst = 1'b0;

    run_xfer(4, 32'h1000, 32'd4, 0, 0, 1'b1, 4'hF);
    run_xfer(3, $urandom(), 32'd8, 1, 0, 1'b1, 4'hF);
    run_xfer(0, $urandom(), 32'd4, 0, 0, 1'b1, 4'hF);
    run_xfer(2, $urandom(), 32'd4, 0, 3, 1'b1, 4'hF);
    run_clear();
    run_xfer(1, $urandom(), 32'd4, 0, 0, 1'b1, 4'hF);
    run_xfer(3, $urandom(), 32'd4, 0, 0, 1'b1, 4'b0011);
    for (int r = 0; r < 8; r++)
      run_xfer($urandom_range(1, 8), $urandom(), $urandom(), 2, $urandom_range(0, 3), 1'b0,
               4'($urandom_range(0, 15)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
